// File: rtl/noc_flit_receiver.sv
// NoC flit receiver: valid/ready ingress buffered in a DEPTH-entry FIFO and re-presented
// in order downstream, with head/tail framing checks and a completed-packet counter.
module noc_flit_receiver #(
  parameter int FLIT_WIDTH    = 64,
  parameter int DEPTH         = 4,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [FLIT_WIDTH-1:0]    i_flit,
  input  logic                     i_head,
  input  logic                     i_tail,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [FLIT_WIDTH-1:0]    o_flit,
  output logic                     o_head,
  output logic                     o_tail,
  output logic                     o_in_packet,
  output logic [PKT_CNT_WIDTH-1:0] o_packet_count,
  output logic                     o_error_pulse,
  output logic                     o_error_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  state_t                state;
  logic [FLIT_WIDTH-1:0] mem_flit [DEPTH];
  logic [DEPTH-1:0]      mem_head;
  logic [DEPTH-1:0]      mem_tail;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      next_count;
  logic                  accept;
  logic                  rel;
  logic                  violation;
  state_t                next_state;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // o_ready is registered so neither i_valid nor i_ready reaches it combinationally.
  assign accept  = i_valid & o_ready;
  assign rel     = o_valid & i_ready;
  assign o_valid = (count != '0);

  // Gated so the outputs read zero while empty and during reset.
  assign o_flit      = o_valid ? mem_flit[rd_ptr] : '0;
  assign o_head      = o_valid & mem_head[rd_ptr];
  assign o_tail      = o_valid & mem_tail[rd_ptr];
  assign o_in_packet = (state == S_IN_PKT);

  always_comb begin
    next_count = count;
    if (accept && !rel)
      next_count = count + CNT_W'(1);
    else if (!accept && rel)
      next_count = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_flit[wr_ptr] <= i_flit;
      mem_head[wr_ptr] <= i_head;
      mem_tail[wr_ptr] <= i_tail;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (rel)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count   <= next_count;
      o_ready <= (next_count < FULL_CNT);
    end
  end

  // A head while idle opens a packet unless it is also a tail; any tail closes it.
  always_comb begin
    violation  = 1'b0;
    next_state = state;
    if (state == S_IDLE) begin
      violation = ~i_head;
      if (i_head && !i_tail)
        next_state = S_IN_PKT;
    end else begin
      violation = i_head;
      if (i_tail)
        next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      o_packet_count <= '0;
      o_error_pulse  <= 1'b0;
      o_error_sticky <= 1'b0;
    end else begin
      o_error_pulse <= accept & violation;
      if (accept) begin
        state <= next_state;
        if (i_tail)
          o_packet_count <= o_packet_count + PKT_CNT_WIDTH'(1);
        if (violation)
          o_error_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Directed bench for noc_flit_receiver: scoreboard queue of accepted flits is checked
// against every released flit, plus directed checks on ready, framing and reset.
module tb_noc_flit_receiver;

  localparam int FW = 64;
  localparam int W  = FW + 2;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [FW-1:0] i_flit;
  logic          i_head;
  logic          i_tail;
  logic          o_valid;
  logic          i_ready;
  logic [FW-1:0] o_flit;
  logic          o_head;
  logic          o_tail;
  logic          o_in_packet;
  logic [15:0]   o_packet_count;
  logic          o_error_pulse;
  logic          o_error_sticky;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int inpkt_cycles = 0;
  int err_pulses = 0;
  bit rand_ready = 0;

  noc_flit_receiver #(.FLIT_WIDTH(FW), .DEPTH(4), .PKT_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit), .i_head(i_head), .i_tail(i_tail),
    .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit), .o_head(o_head), .o_tail(o_tail),
    .o_in_packet(o_in_packet), .o_packet_count(o_packet_count),
    .o_error_pulse(o_error_pulse), .o_error_sticky(o_error_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on accept, pop and compare on release
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        check("sb_nonempty", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0)
          check("sb_flit", {o_head, o_tail, o_flit}, exp_q.pop_front());
      end
      if (i_valid && o_ready)
        exp_q.push_back({i_head, i_tail, i_flit});
      if (o_in_packet) inpkt_cycles++;
      if (o_error_pulse) err_pulses++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic h, input logic t);
    logic got;
    int n;
    got = 1'b0;
    n = 0;
    i_valid = 1'b1;
    i_flit  = f;
    i_head  = h;
    i_tail  = t;
    do begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = o_ready;
      step();
      n++;
    end while (!got && n < 200);
    check("send_accepted", W'(got), W'(1));
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (o_valid && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", W'(o_valid), W'(0));
    check("drain_sb_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    i_valid = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int idx;
    logic acc;
    rst = 1'b1;
    i_valid = 1'b0;
    i_flit = '0;
    i_head = 1'b0;
    i_tail = 1'b0;
    i_ready = 1'b0;

    // reset state
    #12;
    check("rst_ready", W'(o_ready), W'(0));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_outs", {o_head, o_tail, o_flit}, W'(0));
    check("rst_misc", W'({o_in_packet, o_packet_count, o_error_pulse, o_error_sticky}), W'(0));
    step();
    rst = 1'b0;
    #1;
    check("ready_before_edge", W'(o_ready), W'(0));
    step();
    check("ready_after_edge", W'(o_ready), W'(1));

    // 3-flit packet, back-to-back, consumer always ready
    i_ready = 1'b1;
    inpkt_cycles = 0;
    err_pulses = 0;
    send(64'hA, 1'b1, 1'b0);
    check("t1_lat_a", W'({o_valid, o_flit}), W'({1'b1, 64'hA}));
    send(64'hB, 1'b0, 1'b0);
    check("t1_lat_b", W'({o_valid, o_flit}), W'({1'b1, 64'hB}));
    send(64'hC, 1'b0, 1'b1);
    check("t1_lat_c", W'({o_valid, o_flit}), W'({1'b1, 64'hC}));
    step();
    step();
    check("t1_pkt_count", W'(o_packet_count), W'(1));
    check("t1_inpkt_cycles", W'(inpkt_cycles), W'(2));
    check("t1_no_err", W'({o_error_sticky, 32'(err_pulses)}), W'(0));

    // backpressure fill: 6 offered, 4 accepted
    i_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      i_valid = (idx < 6);
      i_flit = 64'h100 + 64'(idx);
      i_head = 1'b1;
      i_tail = 1'b1;
      @(negedge clk);
      acc = i_valid && o_ready;
      step();
      if (acc) begin
        idx++;
        if (idx == 4) check("t2_ready_at_full", W'(o_ready), W'(0));
      end
    end
    check("t2_accepted", W'(idx), W'(4));
    check("t2_ready_held", W'(o_ready), W'(0));
    i_ready = 1'b1;
    step();
    check("t2_ready_after_release", W'(o_ready), W'(1));
    for (int c = 0; c < 20 && idx < 6; c++) begin
      i_valid = 1'b1;
      i_flit = 64'h100 + 64'(idx);
      @(negedge clk);
      acc = o_ready;
      step();
      if (acc) idx++;
    end
    i_valid = 1'b0;
    check("t2_all_accepted", W'(idx), W'(6));
    drain();

    // simultaneous accept/release at count=2
    i_ready = 1'b0;
    send(64'h200, 1'b1, 1'b1);
    send(64'h201, 1'b1, 1'b1);
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_flit = 64'h300 + 64'(k);
      i_head = 1'b1;
      i_tail = 1'b1;
      @(negedge clk);
      check("t3_ready", W'({o_ready, o_valid}), W'(2'b11));
      step();
    end
    i_valid = 1'b0;
    step();
    check("t3_count_one", W'(o_valid), W'(1));
    step();
    check("t3_count_zero", W'(o_valid), W'(0));
    check("t3_sb_empty", W'(exp_q.size()), W'(0));

    // wrap-around with random consumer readiness
    do_reset();
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) send(64'(p), 1'b1, 1'b1);
    rand_ready = 1'b0;
    drain();
    check("t4_pkt_count", W'(o_packet_count), W'(20));
    check("t4_no_err", W'(o_error_sticky), W'(0));

    // framing errors
    do_reset();
    i_ready = 1'b1;
    err_pulses = 0;
    send(64'h51, 1'b0, 1'b0);
    check("t5_pulse_body_idle", W'(o_error_pulse), W'(1));
    send(64'h52, 1'b1, 1'b0);
    check("t5_pulse_head_ok", W'(o_error_pulse), W'(0));
    send(64'h53, 1'b1, 1'b0);
    check("t5_pulse_second_head", W'(o_error_pulse), W'(1));
    step();
    check("t5_pulse_one_cycle", W'(o_error_pulse), W'(0));
    step();
    check("t5_pulse_total", W'(err_pulses), W'(2));
    check("t5_sticky", W'(o_error_sticky), W'(1));
    check("t5_in_packet", W'(o_in_packet), W'(1));
    drain();

    // async reset mid-packet with three flits buffered
    i_ready = 1'b0;
    send(64'h61, 1'b1, 1'b1);
    send(64'h62, 1'b1, 1'b0);
    send(64'h63, 1'b0, 1'b0);
    check("t6_pre_state", W'({o_valid, o_in_packet, o_packet_count}), W'({1'b1, 1'b1, 16'd1}));
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_async_clear", W'({o_valid, o_ready, o_in_packet, o_packet_count}), W'(0));
    check("t6_async_sticky", W'(o_error_sticky), W'(0));
    step();
    rst = 1'b0;
    step();
    i_ready = 1'b1;
    send(64'h71, 1'b1, 1'b0);
    send(64'h72, 1'b0, 1'b0);
    send(64'h73, 1'b0, 1'b1);
    drain();
    check("t6_new_pkt_count", W'(o_packet_count), W'(1));
    check("t6_new_no_err", W'({o_error_sticky, o_in_packet}), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
